// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline: load-use, branch flush, MDU wait, dmem wait + watchdog.
// Optional macro PERF_CNT_EN adds saturating stall/flush counters (ports tied to 0 when undefined).
module pipeline_stall_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        ID_EX_MemRead_i,
   input  logic [4:0]  ID_EX_RegRt_i,
   input  logic [4:0]  IF_ID_RegRs_i,
   input  logic [4:0]  IF_ID_RegRt_i,
   input  logic        branch_taken_i,
   input  logic        mdu_req_i,
   input  logic        mdu_done_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ack_i,
   output logic        pc_write_o,
   output logic        if_id_write_o,
   output logic        if_id_flush_o,
   output logic        id_ex_write_o,
   output logic        id_ex_bubble_o,
   output logic        ex_mem_write_o,
   output logic        ex_mem_bubble_o,
   output logic        mem_wb_bubble_o,
   output logic        mdu_go_o,
   output logic        err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_wdog;
   logic [CNT_W-1:0] w_wdog_next;
   logic             w_memstall;
   logic             w_loaduse;
   logic             w_wdog_hit;

   assign w_memstall = dmem_req_i & ~dmem_ack_i;
   assign w_loaduse  = ID_EX_MemRead_i & (ID_EX_RegRt_i != 5'd0) &
                       ((ID_EX_RegRt_i == IF_ID_RegRs_i) | (ID_EX_RegRt_i == IF_ID_RegRt_i));
   assign w_wdog_hit = w_memstall & (r_wdog == CNT_W'(TIMEOUT - 1));
   assign dbg_state_o = r_state;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= RUN;
         r_wdog  <= '0;
      end else begin
         r_state <= w_next;
         r_wdog  <= w_wdog_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      w_wdog_next     = '0;
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
      if_id_flush_o   = 1'b0;
      id_ex_write_o   = 1'b1;
      id_ex_bubble_o  = 1'b0;
      ex_mem_write_o  = 1'b1;
      ex_mem_bubble_o = 1'b0;
      mem_wb_bubble_o = 1'b0;
      mdu_go_o        = 1'b0;
      err_o           = 1'b0;

      if (r_state != ERR && w_memstall) begin
         w_wdog_next = r_wdog + CNT_W'(1);
      end

      case (r_state)
         RUN: begin
            if (w_memstall) begin
               pc_write_o      = 1'b0;
               if_id_write_o   = 1'b0;
               id_ex_write_o   = 1'b0;
               ex_mem_write_o  = 1'b0;
               mem_wb_bubble_o = 1'b1;
               if (w_wdog_hit) w_next = ERR;
            end else if (mdu_req_i) begin
               pc_write_o      = 1'b0;
               if_id_write_o   = 1'b0;
               id_ex_write_o   = 1'b0;
               ex_mem_bubble_o = 1'b1;
               mdu_go_o        = 1'b1;
               w_next          = MDU_WAIT;
            end else if (w_loaduse) begin
               pc_write_o      = 1'b0;
               if_id_write_o   = 1'b0;
               id_ex_bubble_o  = 1'b1;
            end else if (branch_taken_i) begin
               if_id_flush_o   = 1'b1;
            end
         end
         MDU_WAIT: begin
            pc_write_o      = 1'b0;
            if_id_write_o   = 1'b0;
            id_ex_write_o   = 1'b0;
            ex_mem_bubble_o = 1'b1;
            if (w_memstall) begin
               // EX/MEM must hold its occupant while MEM is frozen, so no bubble either
               ex_mem_write_o  = 1'b0;
               ex_mem_bubble_o = 1'b0;
               mem_wb_bubble_o = 1'b1;
               if (w_wdog_hit) w_next = ERR;
            end else if (mdu_done_i) begin
               pc_write_o      = 1'b1;
               if_id_write_o   = 1'b1;
               id_ex_write_o   = 1'b1;
               ex_mem_bubble_o = 1'b0;
               w_next          = RUN;
            end
         end
         ERR: begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_write_o  = 1'b0;
            ex_mem_write_o = 1'b0;
            err_o          = 1'b1;
         end
         default: begin
            w_next = RUN;
         end
      endcase

      // Reset silences every control immediately, not at the next edge
      if (!rst_n_i) begin
         pc_write_o      = 1'b0;
         if_id_write_o   = 1'b0;
         if_id_flush_o   = 1'b0;
         id_ex_write_o   = 1'b0;
         id_ex_bubble_o  = 1'b0;
         ex_mem_write_o  = 1'b0;
         ex_mem_bubble_o = 1'b0;
         mem_wb_bubble_o = 1'b0;
         mdu_go_o        = 1'b0;
         err_o           = 1'b0;
      end
   end

`ifdef PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (r_state != ERR && !pc_write_o && r_stall_cnt != 32'hFFFF_FFFF)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (if_id_flush_o && r_flush_cnt != 32'hFFFF_FFFF)
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule
